axi_lite_mem_master: RTL



---
 rtl/axi_lite_mem_master_if.sv | 37 +++
 rtl/axi_lite_mem_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_master_if.sv
// AXI4-Lite write (AW/W/B) and read (AR/R) channel bundle between the CPU bridge and the memory slave.
interface axi_lite_mem_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// Bridges the CPU load/store port onto AXI4-Lite, one transaction at a time, with a per-transaction
// watchdog that forces completion (resp 11) if the slave stalls.
//   state     | meaning
//   S_IDLE    | waiting for cpu_req
//   S_WR_REQ  | AWVALID/WVALID up, each dropped on its own handshake
//   S_WR_RESP | BREADY up, waiting for BVALID
//   S_RD_ADDR | ARVALID up, waiting for ARREADY
//   S_RD_DATA | RREADY up, waiting for RVALID
//   S_DONE    | cpu_done pulse, busy clears on exit
module axi_lite_mem_master #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PROT           = 3'b000,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                    ACLK,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic                    cpu_busy,
  output logic                    cpu_done,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic [1:0]              cpu_resp,
  output logic                    cpu_err,
  axi_lite_mem_master_if.master   axi
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]      state;
  logic [WD_W-1:0] wd_cnt;
  logic            in_flight;
  logic            final_hs;
  logic            wd_expire;

  assign axi.AWPROT = PROT;
  assign axi.ARPROT = PROT;

  assign in_flight = (state != S_IDLE) && (state != S_DONE);
  assign final_hs  = ((state == S_WR_RESP) && axi.BVALID && axi.BREADY) ||
                     ((state == S_RD_DATA) && axi.RVALID && axi.RREADY);
  // The edge on which the counter would reach TIMEOUT_CYCLES is the abort edge.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && in_flight && (wd_cnt == WD_LAST) && !final_hs;

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state       <= S_IDLE;
      wd_cnt      <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      cpu_resp    <= 2'b00;
      axi.AWADDR  <= '0;
      axi.AWVALID <= 1'b0;
      axi.WDATA   <= '0;
      axi.WSTRB   <= '0;
      axi.WVALID  <= 1'b0;
      axi.BREADY  <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARVALID <= 1'b0;
      axi.RREADY  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      if (in_flight) wd_cnt <= wd_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            cpu_busy <= 1'b1;
            wd_cnt   <= '0;
            if (cpu_we) begin
              axi.AWADDR  <= cpu_addr;
              axi.WDATA   <= cpu_wdata;
              axi.WSTRB   <= cpu_wstrb;
              axi.AWVALID <= 1'b1;
              axi.WVALID  <= 1'b1;
              state       <= S_WR_REQ;
            end else begin
              axi.ARADDR  <= cpu_addr;
              axi.ARVALID <= 1'b1;
              state       <= S_RD_ADDR;
            end
          end
        end
        S_WR_REQ: begin
          if (axi.AWVALID && axi.AWREADY) axi.AWVALID <= 1'b0;
          if (axi.WVALID && axi.WREADY) axi.WVALID <= 1'b0;
          // A low VALID in this state means that channel already handshook on an earlier edge.
          if ((!axi.AWVALID || axi.AWREADY) && (!axi.WVALID || axi.WREADY)) begin
            axi.BREADY <= 1'b1;
            state      <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi.BVALID) begin
            axi.BREADY <= 1'b0;
            cpu_resp   <= axi.BRESP;
            cpu_done   <= 1'b1;
            cpu_err    <= |axi.BRESP;
            state      <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (axi.ARREADY) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
            state       <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.RVALID) begin
            axi.RREADY <= 1'b0;
            cpu_rdata  <= axi.RDATA;
            cpu_resp   <= axi.RRESP;
            cpu_done   <= 1'b1;
            cpu_err    <= |axi.RRESP;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          cpu_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Abort overrides whatever the state logic scheduled on this edge.
      if (wd_expire) begin
        axi.AWVALID <= 1'b0;
        axi.WVALID  <= 1'b0;
        axi.BREADY  <= 1'b0;
        axi.ARVALID <= 1'b0;
        axi.RREADY  <= 1'b0;
        cpu_resp    <= 2'b11;
        cpu_done    <= 1'b1;
        cpu_err     <= 1'b1;
        state       <= S_DONE;
      end
    end
  end
endmodule
